// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one icache read at a time, presents the
// fetched word to IF/ID and handles redirects from the branch unit.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    input  logic        stall,
    output logic        read_flag,
    output logic [31:0] addr,
    input  logic [31:0] read_data,
    input  logic        busy,
    input  logic        done,
    output logic [31:0] inst,
    output logic [31:0] pc_addr,
    output logic        inst_valid,
    output logic [15:0] fetch_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        kill_reg, kill_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] pc_addr_reg, pc_addr_next;
    logic        valid_reg, valid_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [31:0] target;

    // Redirect targets are always word aligned.
    assign target = jump_addr & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            pc_reg      <= RESET_PC;
            kill_reg    <= 1'b0;
            inst_reg    <= 32'd0;
            pc_addr_reg <= 32'd0;
            valid_reg   <= 1'b0;
            cnt_reg     <= 16'd0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            kill_reg    <= kill_next;
            inst_reg    <= inst_next;
            pc_addr_reg <= pc_addr_next;
            valid_reg   <= valid_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        kill_next    = kill_reg;
        inst_next    = inst_reg;
        pc_addr_next = pc_addr_reg;
        valid_next   = valid_reg;
        cnt_next     = cnt_reg;
        case (state_reg)
            IDLE: begin
                state_next = REQ;
                if (jump_en) pc_next = target;
            end
            REQ: begin
                if (jump_en) begin
                    pc_next = target;
                end else if (!busy) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (jump_en) begin
                    pc_next = target;
                    // Without a response yet, remember to drop it when it lands.
                    if (done) begin
                        kill_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        kill_next = 1'b1;
                    end
                end else if (done) begin
                    if (kill_reg) begin
                        kill_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        inst_next    = read_data;
                        pc_addr_next = pc_reg;
                        valid_next   = 1'b1;
                        state_next   = OUT;
                    end
                end
            end
            OUT: begin
                if (jump_en) begin
                    valid_next = 1'b0;
                    pc_next    = target;
                    state_next = REQ;
                end else if (!stall) begin
                    valid_next = 1'b0;
                    pc_next    = pc_reg + 32'd4;
                    cnt_next   = cnt_reg + 16'd1;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign read_flag  = (state_reg == REQ) && !busy && !jump_en;
    assign addr       = pc_reg;
    assign inst       = inst_reg;
    assign pc_addr    = pc_addr_reg;
    assign inst_valid = valid_reg;
    assign fetch_cnt  = cnt_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: icache responder, random/directed stimulus
// and a scoreboard predicting the delivered instruction stream from pc/jump rules.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = 32'd0;
    logic        stall = 1'b0;
    logic        read_flag;
    logic [31:0] addr;
    logic [31:0] read_data = 32'd0;
    logic        busy = 1'b0;
    logic        done = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc_addr;
    logic        inst_valid;
    logic [15:0] fetch_cnt;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .jump_en(jump_en), .jump_addr(jump_addr), .stall(stall),
        .read_flag(read_flag), .addr(addr), .read_data(read_data), .busy(busy), .done(done),
        .inst(inst), .pc_addr(pc_addr), .inst_valid(inst_valid), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    int assert_cnt = 0;
    int fail_cnt = 0;
    int xfer_total = 0;

    // control knobs written only by the main process
    bit force_busy = 1'b0;
    bit rand_busy = 1'b0;
    bit inject_done = 1'b0;
    // written only by the responder
    bit pending = 1'b0;

    // scoreboard: addresses of the next instruction expected downstream
    logic [31:0] exp_q[$];
    logic [15:0] model_cnt = 16'd0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEADBEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // icache model: one response per request, 1..3 cycles after the request edge
    initial begin : responder
        bit          got_req;
        logic [31:0] req_a;
        logic [31:0] raddr;
        int          delay;
        bit          pend;
        pend = 1'b0;
        delay = 0;
        raddr = 32'd0;
        forever begin
            @(negedge clk);
            got_req = rst && (read_flag === 1'b1);
            req_a = addr;
            @(posedge clk);
            #1;
            done = 1'b0;
            if (!rst) begin
                pend = 1'b0;
            end else if (got_req) begin
                pend = 1'b1;
                raddr = req_a;
                delay = $urandom_range(1, 3);
            end else if (pend) begin
                delay--;
                if (delay == 0) begin
                    done = 1'b1;
                    read_data = mem_word(raddr);
                    pend = 1'b0;
                end
            end
            if (inject_done) begin
                done = 1'b1;
                read_data = 32'hBAD0_BAD0;
            end
            busy = force_busy || (rand_busy && ($urandom_range(0, 3) == 0));
            pending = pend;
        end
    end

    // monitor: inputs and outputs are stable at negedge and describe the coming edge
    initial begin : monitor
        bit          hold;
        logic [31:0] h_inst, h_pc, e;
        hold = 1'b0;
        h_inst = 32'd0;
        h_pc = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_read_flag", read_flag, 0);
                check("rst_inst_valid", inst_valid, 0);
                check("rst_inst", inst, 0);
                check("rst_pc_addr", pc_addr, 0);
                check("rst_fetch_cnt", fetch_cnt, 0);
                check("rst_addr", addr, RESET_PC);
                exp_q.delete();
                exp_q.push_back(RESET_PC);
                model_cnt = 16'd0;
                hold = 1'b0;
            end else begin
                check("fetch_cnt", fetch_cnt, model_cnt);
                if (hold) begin
                    check("hold_valid", inst_valid, 1);
                    check("hold_inst", inst, h_inst);
                    check("hold_pc_addr", pc_addr, h_pc);
                    hold = 1'b0;
                end
                if (busy || jump_en) check("read_flag_blocked", read_flag, 0);
                if (read_flag) check("req_addr", addr, exp_q[0]);
                if (inst_valid && !jump_en && !stall) begin
                    e = exp_q.pop_front();
                    check("xfer_pc_addr", pc_addr, e);
                    check("xfer_inst", inst, mem_word(e));
                    exp_q.push_back(e + 32'd4);
                    model_cnt = model_cnt + 16'd1;
                    xfer_total++;
                end else if (inst_valid && !jump_en && stall) begin
                    hold = 1'b1;
                    h_inst = inst;
                    h_pc = pc_addr;
                end
                if (jump_en) begin
                    exp_q.delete();
                    exp_q.push_back(jump_addr & 32'hFFFF_FFFC);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_xfers(int n);
        int target;
        target = xfer_total + n;
        for (int i = 0; i < 400 && xfer_total < target; i++) tick();
        check("xfer_timeout", (xfer_total >= target), 1);
    endtask

    task automatic wait_pending();
        int i;
        for (i = 0; i < 100 && !pending; i++) tick();
        check("pending_timeout", pending, 1);
    endtask

    task automatic do_jump(logic [31:0] a);
        jump_en = 1'b1;
        jump_addr = a;
        tick();
        jump_en = 1'b0;
    endtask

    initial begin : main
        int start_cnt;
        repeat (3) tick();
        rst = 1'b1;

        // straight-line fetch from reset
        wait_xfers(3);
        @(negedge clk);
        check("three_fetches", fetch_cnt, 3);
        tick();

        // icache busy holds the request
        force_busy = 1'b1;
        repeat (5) tick();
        force_busy = 1'b0;
        wait_xfers(1);

        // stalled delivery of DEADBEEF
        stall = 1'b1;
        do_jump(32'h0000_0100);
        for (int i = 0; i < 50 && !inst_valid; i++) tick();
        start_cnt = int'(fetch_cnt);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_inst", inst, 32'hDEADBEEF);
            check("stall_pc_addr", pc_addr, 32'h0000_0100);
            check("stall_cnt", fetch_cnt, start_cnt[15:0]);
        end
        tick();
        stall = 1'b0;
        tick();
        @(negedge clk);
        check("stall_release_cnt", fetch_cnt, start_cnt[15:0] + 16'd1);

        // redirect while waiting for the icache
        wait_pending();
        do_jump(32'h0000_1003);
        wait_xfers(2);

        // redirect coincident with done
        for (int i = 0; i < 100 && !done; i++) tick();
        check("saw_done", done, 1);
        do_jump($urandom);
        wait_xfers(1);

        // redirect while presenting an instruction with stall low
        for (int i = 0; i < 100 && !inst_valid; i++) tick();
        check("saw_valid", inst_valid, 1);
        start_cnt = int'(fetch_cnt);
        do_jump($urandom);
        @(negedge clk);
        check("jump_out_valid", inst_valid, 0);
        check("jump_out_cnt", fetch_cnt, start_cnt[15:0]);
        wait_xfers(1);

        // pc wraps past the top of the address space
        do_jump(32'hFFFF_FFFC);
        wait_xfers(2);

        // randomized traffic
        rand_busy = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            jump_en = ($urandom_range(0, 11) == 0);
            jump_addr = $urandom;
            stall = ($urandom_range(0, 2) == 0);
            tick();
        end
        jump_en = 1'b0;
        stall = 1'b0;
        rand_busy = 1'b0;
        wait_xfers(1);

        // asynchronous reset while waiting, then a stray completion
        wait_pending();
        #1;
        rst = 1'b0;
        force_busy = 1'b1;
        #1;
        check("async_read_flag", read_flag, 0);
        check("async_inst_valid", inst_valid, 0);
        check("async_inst", inst, 0);
        check("async_pc_addr", pc_addr, 0);
        check("async_fetch_cnt", fetch_cnt, 0);
        check("async_addr", addr, RESET_PC);
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stray_done_valid", inst_valid, 0);
        end
        force_busy = 1'b0;
        wait_xfers(3);

        check("traffic_volume", (xfer_total > 100), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 jump_en  input  1  single-cycle redirect request from the branch unit.
REQ-005 jump_addr  input  32  redirect target, sampled when jump_en=1.
REQ-006 stall  input  1  downstream IF/ID back-pressure.
REQ-007 read_flag  output  1  icache read request.
REQ-008 addr  output  32  icache read address.
REQ-009 read_data  input  32  icache read data, valid when done=1.
REQ-010 busy  input  1  icache cannot accept a request.
REQ-011 done  input  1  single-cycle icache completion.
REQ-012 inst  output  32  fetched instruction to IF/ID.
REQ-013 pc_addr  output  32  address of inst.
REQ-014 inst_valid  output  1  inst/pc_addr valid.
REQ-015 fetch_cnt  output  16  count of instructions delivered downstream.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, REQ, WAIT and OUT; at most one icache request SHALL be outstanding.
REQ-017 IDLE SHALL go to REQ on the first clock edge after reset deasserts.
REQ-018 read_flag SHALL be combinational: (state==REQ) && !busy && !jump_en; addr SHALL equal the pc register at all times.
REQ-019 REQ SHALL go to WAIT on the edge where read_flag=1; REQ with busy=1 SHALL stay in REQ.
REQ-020 WAIT with done=1 and kill=0 SHALL register inst<=read_data and pc_addr<=pc, then go to OUT; inst_valid=1 therefore appears the cycle after done.
REQ-021 OUT SHALL hold inst_valid=1 with inst and pc_addr stable while stall=1.
REQ-022 Transfer SHALL occur on a cycle with inst_valid=1 and stall=0; on that edge inst_valid<=0, pc<=pc+4, fetch_cnt<=fetch_cnt+1, and the state goes to REQ.
REQ-023 pc+4 SHALL wrap modulo 2^32; fetch_cnt SHALL wrap 16'hFFFF->0.
REQ-024 jump_en SHALL have priority over every other event; the redirect target SHALL be {jump_addr[31:2],2'b00}.
REQ-025 jump_en in IDLE or REQ SHALL load pc<=target; no read is issued that cycle; state goes to or stays in REQ.
REQ-026 jump_en in WAIT with done=0 SHALL load pc<=target and set kill=1.
REQ-027 In WAIT with kill=1, done SHALL be discarded: kill<=0, no output update, go to REQ.
REQ-028 jump_en in WAIT coincident with done SHALL discard that response, load pc<=target, and go to REQ.
REQ-029 jump_en in OUT SHALL drop inst_valid next cycle with no transfer and fetch_cnt unchanged, even if stall=0; pc<=target; go to REQ.
REQ-030 done outside WAIT SHALL be ignored; stall SHALL have no effect in IDLE, REQ or WAIT.

Reset
REQ-031 While rst=0, regardless of clk: state=IDLE, pc=RESET_PC, kill=0, inst=0, pc_addr=0, inst_valid=0, fetch_cnt=0; read_flag SHALL be 0.
REQ-032 Reset asserted mid-request SHALL abandon the request; any later done SHALL be ignored until the FSM returns to WAIT.

Verification
REQ-033 Release reset with RESET_PC=0, busy=0, and done 2 cycles after each request, stall=0 -> addr sequence 0,4,8; inst_valid pulses with pc_addr 0,4,8; fetch_cnt=3.
REQ-034 busy=1 for 5 cycles in REQ -> read_flag=0 throughout; a single request to the same addr on the cycle busy drops.
REQ-035 Deliver inst=32'hDEADBEEF, then hold stall=1 for 4 cycles -> inst_valid, inst and pc_addr stable for 4 cycles; fetch_cnt increments once, on the stall release edge.
REQ-036 jump_en with jump_addr=32'h0000_1003 in WAIT, done 2 cycles later -> no inst_valid for that response; next request addr=32'h0000_1000.
REQ-037 jump_en in the same cycle as done -> response discarded; next addr=target. jump_en in OUT with stall=0 -> no transfer; fetch_cnt unchanged.
REQ-038 pc=32'hFFFF_FFFC transfers -> next addr=0. Assert rst=0 asynchronously in WAIT -> all outputs 0 immediately; a subsequent stray done produces no inst_valid.
